alu_gate_arbiter: RTL and testbench

- Two-requester round-robin arbiter and sequencer that shares one combinational AluGate between requesters.
- Accepts an operation from a requester with a valid/ready handshake and latches its operands.
- Drives the AluGate from registers, captures the result, and returns it on a response channel tagged with requester id and destination register.
- Sits between the decode/issue stage and the shared AluGate instance in simple_processor.

---
 rtl/alu_gate_arbiter_if.sv | 46 ++++
 rtl/alu_gate_arbiter.sv | 112 +++++++++++
 tb/tb_alu_gate_arbiter.sv | 263 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/alu_gate_arbiter_if.sv
// Request/response bundle between two issuing requesters, the ALU arbiter and the
// result consumer. The arbiter takes the slave side; requesters and consumer take the master side.
interface alu_gate_arbiter_if #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 5,
    parameter int FUNC_WIDTH = 3
);
    logic                  req0_valid_i;
    logic                  req0_ready_o;
    logic [DATA_WIDTH-1:0] req0_rs1_i;
    logic [DATA_WIDTH-1:0] req0_rs2_i;
    logic [FUNC_WIDTH-1:0] req0_func_i;
    logic [ADDR_WIDTH-1:0] req0_rd_addr_i;

    logic                  req1_valid_i;
    logic                  req1_ready_o;
    logic [DATA_WIDTH-1:0] req1_rs1_i;
    logic [DATA_WIDTH-1:0] req1_rs2_i;
    logic [FUNC_WIDTH-1:0] req1_func_i;
    logic [ADDR_WIDTH-1:0] req1_rd_addr_i;

    logic                  rsp_valid_o;
    logic                  rsp_ready_i;
    logic                  rsp_id_o;
    logic [ADDR_WIDTH-1:0] rsp_rd_addr_o;
    logic [DATA_WIDTH-1:0] rsp_data_o;
    logic                  rsp_err_o;

    modport slave (
        input  req0_valid_i, req0_rs1_i, req0_rs2_i, req0_func_i, req0_rd_addr_i,
        output req0_ready_o,
        input  req1_valid_i, req1_rs1_i, req1_rs2_i, req1_func_i, req1_rd_addr_i,
        output req1_ready_o,
        output rsp_valid_o, rsp_id_o, rsp_rd_addr_o, rsp_data_o, rsp_err_o,
        input  rsp_ready_i
    );

    modport master (
        output req0_valid_i, req0_rs1_i, req0_rs2_i, req0_func_i, req0_rd_addr_i,
        input  req0_ready_o,
        output req1_valid_i, req1_rs1_i, req1_rs2_i, req1_func_i, req1_rd_addr_i,
        input  req1_ready_o,
        input  rsp_valid_o, rsp_id_o, rsp_rd_addr_o, rsp_data_o, rsp_err_o,
        output rsp_ready_i
    );
endinterface

// File: rtl/alu_gate_arbiter.sv
// Round-robin arbiter/sequencer sharing one combinational AluGate between two requesters.
// Each operation walks IDLE (accept) -> EXEC (drive ALU, capture) -> RESP (hold until taken).
module alu_gate_arbiter #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 5,
    parameter int FUNC_WIDTH = 3,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                  clk_i,
    input  logic                  arst_ni,
    alu_gate_arbiter_if.slave     bus,
    output logic [DATA_WIDTH-1:0] alu_rs1_o,
    output logic [DATA_WIDTH-1:0] alu_rs2_o,
    output logic [FUNC_WIDTH-1:0] alu_func_o,
    input  logic [DATA_WIDTH-1:0] alu_rd_data_i,
    output logic                  busy_o,
    output logic [CNT_WIDTH-1:0]  op_count_o
);

    typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

    localparam logic [FUNC_WIDTH-1:0] FUNC_MAX = FUNC_WIDTH'(3);

    function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] v);
        return (&v) ? v : v + CNT_WIDTH'(1);
    endfunction

    state_t                state_q, state_d;
    logic                  last_grant_q;
    logic                  accept, gnt_id;
    logic [DATA_WIDTH-1:0] rs1_q, rs2_q, res_q;
    logic [FUNC_WIDTH-1:0] func_q;
    logic [ADDR_WIDTH-1:0] rd_q;
    logic                  id_q, err_q;
    logic [CNT_WIDTH-1:0]  cnt_q;

    always_ff @(posedge clk_i or negedge arst_ni) begin
        if (!arst_ni) begin
            state_q      <= IDLE;
            last_grant_q <= 1'b1;
        end else begin
            state_q <= state_d;
            if (accept) last_grant_q <= gnt_id;
        end
    end

    // Arbitration and next state: on a tie the requester not granted last time wins.
    always_comb begin
        state_d = state_q;
        accept  = 1'b0;
        gnt_id  = 1'b0;
        case (state_q)
            IDLE: begin
                if (bus.req0_valid_i && bus.req1_valid_i) begin
                    accept = 1'b1;
                    gnt_id = ~last_grant_q;
                end else if (bus.req0_valid_i) begin
                    accept = 1'b1;
                end else if (bus.req1_valid_i) begin
                    accept = 1'b1;
                    gnt_id = 1'b1;
                end
                if (accept) state_d = EXEC;
            end
            EXEC:    state_d = RESP;
            RESP:    if (bus.rsp_ready_i) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    assign bus.req0_ready_o = accept & ~gnt_id;
    assign bus.req1_ready_o = accept &  gnt_id;

    // Operand latch on accept, result capture in EXEC, count on response handshake.
    always_ff @(posedge clk_i or negedge arst_ni) begin
        if (!arst_ni) begin
            rs1_q  <= '0;
            rs2_q  <= '0;
            func_q <= '0;
            rd_q   <= '0;
            id_q   <= 1'b0;
            res_q  <= '0;
            err_q  <= 1'b0;
            cnt_q  <= '0;
        end else begin
            if (accept) begin
                rs1_q  <= gnt_id ? bus.req1_rs1_i     : bus.req0_rs1_i;
                rs2_q  <= gnt_id ? bus.req1_rs2_i     : bus.req0_rs2_i;
                func_q <= gnt_id ? bus.req1_func_i    : bus.req0_func_i;
                rd_q   <= gnt_id ? bus.req1_rd_addr_i : bus.req0_rd_addr_i;
                id_q   <= gnt_id;
            end
            if (state_q == EXEC) begin
                res_q <= (func_q <= FUNC_MAX) ? alu_rd_data_i : '0;
                err_q <= (func_q > FUNC_MAX);
            end
            if (state_q == RESP && bus.rsp_ready_i) cnt_q <= sat_inc(cnt_q);
        end
    end

    assign alu_rs1_o         = rs1_q;
    assign alu_rs2_o         = rs2_q;
    assign alu_func_o        = func_q;
    assign bus.rsp_valid_o   = (state_q == RESP);
    assign bus.rsp_id_o      = id_q;
    assign bus.rsp_rd_addr_o = rd_q;
    assign bus.rsp_data_o    = res_q;
    assign bus.rsp_err_o     = err_q;
    assign busy_o            = (state_q != IDLE);
    assign op_count_o        = cnt_q;

endmodule

// File: tb/tb_alu_gate_arbiter.sv
// Directed bench for alu_gate_arbiter: stimulus pushes expected responses into a queue,
// an independent monitor pops and compares on every response handshake.
module tb_alu_gate_arbiter;

    logic clk_i = 1'b0;
    logic arst_ni;
    always #5 clk_i = ~clk_i;

    alu_gate_arbiter_if bus ();

    logic [31:0] alu_rs1, alu_rs2, alu_rd;
    logic [2:0]  alu_func;
    logic        busy;
    logic [15:0] op_count;

    alu_gate_arbiter dut (
        .clk_i         (clk_i),
        .arst_ni       (arst_ni),
        .bus           (bus),
        .alu_rs1_o     (alu_rs1),
        .alu_rs2_o     (alu_rs2),
        .alu_func_o    (alu_func),
        .alu_rd_data_i (alu_rd),
        .busy_o        (busy),
        .op_count_o    (op_count)
    );

    // AluGate stand-in; garbage for undefined opcodes so the arbiter must mask it.
    always_comb begin
        alu_rd = 32'hDEAD_BEEF;
        case (alu_func)
            3'd0: alu_rd = alu_rs1 & alu_rs2;
            3'd1: alu_rd = alu_rs1 | alu_rs2;
            3'd2: alu_rd = alu_rs1 ^ alu_rs2;
            3'd3: alu_rd = ~alu_rs1;
            default: alu_rd = 32'hDEAD_BEEF;
        endcase
    end

    typedef struct packed {
        logic        id;
        logic [4:0]  rd;
        logic [31:0] data;
        logic        err;
    } rsp_t;

    rsp_t exp_q[$];
    int   n_cmp = 0;
    int   n_bad = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        n_cmp++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, req, $time);
        end
    endtask

    task automatic push(input logic id, input logic [4:0] rd, input logic [31:0] data, input logic err);
        rsp_t e;
        e.id = id; e.rd = rd; e.data = data; e.err = err;
        exp_q.push_back(e);
    endtask

    // Monitor: compare every accepted response against the head of the queue.
    always begin
        rsp_t got, e;
        @(negedge clk_i);
        #2;
        if (arst_ni && bus.rsp_valid_o && bus.rsp_ready_i) begin
            got = {bus.rsp_id_o, bus.rsp_rd_addr_o, bus.rsp_data_o, bus.rsp_err_o};
            if (exp_q.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL rsp_unexpected: got %0h expected none at %0t", got, $time);
            end else begin
                e = exp_q.pop_front();
                check("rsp", 64'(got), 64'(e));
            end
        end
    end

    function automatic logic ready_of(input int id);
        return (id == 0) ? bus.req0_ready_o : bus.req1_ready_o;
    endfunction

    task automatic drive_req(input int id, input logic [31:0] rs1, input logic [31:0] rs2,
                             input logic [2:0] f, input logic [4:0] rd);
        if (id == 0) begin
            bus.req0_rs1_i = rs1; bus.req0_rs2_i = rs2; bus.req0_func_i = f;
            bus.req0_rd_addr_i = rd; bus.req0_valid_i = 1'b1;
        end else begin
            bus.req1_rs1_i = rs1; bus.req1_rs2_i = rs2; bus.req1_func_i = f;
            bus.req1_rd_addr_i = rd; bus.req1_valid_i = 1'b1;
        end
    endtask

    // Called right after a falling edge; returns on the falling edge after the accept edge.
    task automatic wait_accept(input int id);
        int n = 0;
        while (1) begin
            #1;
            if (ready_of(id)) break;
            @(negedge clk_i);
            n++;
            if (n > 60) begin
                n_cmp++;
                n_bad++;
                $display("FAIL accept_timeout: requester %0d got no ready expected ready", id);
                return;
            end
        end
        @(negedge clk_i);
    endtask

    task automatic issue(input int id, input logic [31:0] rs1, input logic [31:0] rs2,
                         input logic [2:0] f, input logic [4:0] rd);
        drive_req(id, rs1, rs2, f, rd);
        wait_accept(id);
    endtask

    task automatic drain();
        int n = 0;
        while (exp_q.size() != 0 && n < 100) begin
            @(negedge clk_i);
            n++;
        end
        if (exp_q.size() != 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL drain_timeout: %0d responses pending expected 0", exp_q.size());
            exp_q.delete();
        end
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rsp_t snap;
        logic [15:0] cb;

        arst_ni = 1'b0;
        bus.req0_valid_i = 1'b0; bus.req0_rs1_i = '0; bus.req0_rs2_i = '0;
        bus.req0_func_i = '0; bus.req0_rd_addr_i = '0;
        bus.req1_valid_i = 1'b0; bus.req1_rs1_i = '0; bus.req1_rs2_i = '0;
        bus.req1_func_i = '0; bus.req1_rd_addr_i = '0;
        bus.rsp_ready_i = 1'b1;

        // Reset state
        #100;
        check("rst_alu", 64'({alu_rs1, alu_rs2, alu_func}), 64'(0));
        check("rst_rsp", 64'({bus.rsp_valid_o, bus.rsp_id_o, bus.rsp_rd_addr_o, bus.rsp_data_o, bus.rsp_err_o}), 64'(0));
        check("rst_busy_cnt", 64'({busy, op_count}), 64'(0));
        @(negedge clk_i);
        arst_ni = 1'b1;
        @(negedge clk_i);
        #1;
        check("post_rst_idle", 64'({busy, op_count, bus.rsp_valid_o, bus.req0_ready_o, bus.req1_ready_o}), 64'(0));
        @(negedge clk_i);

        // Single AND from requester 0, response two cycles after accept
        push(1'b0, 5'd5, 32'h00F0_1234, 1'b0);
        issue(0, 32'hF0F0_1234, 32'h0FF0_FFFF, 3'd0, 5'd5);
        bus.req0_valid_i = 1'b0;
        #1;
        check("single_exec_alu", 64'({alu_rs1, alu_func}), 64'({32'hF0F0_1234, 3'd0}));
        check("single_exec_state", 64'({busy, bus.rsp_valid_o}), 64'({1'b1, 1'b0}));
        @(negedge clk_i);
        #1;
        check("single_resp_valid", 64'(bus.rsp_valid_o), 64'(1));
        drain();
        check("single_count", 64'(op_count), 64'(1));

        // Invalid opcode from requester 1 (also leaves last_grant at 1)
        push(1'b1, 5'd7, 32'h0, 1'b1);
        @(negedge clk_i);
        issue(1, 32'hFFFF_FFFF, 32'h0000_1234, 3'd5, 5'd7);
        bus.req1_valid_i = 1'b0;
        drain();
        check("invalid_count", 64'(op_count), 64'(2));

        // Fairness: both continuously valid, grants alternate starting with requester 0
        for (int i = 0; i < 3; i++) begin
            push(1'b0, 5'(1 + i),  32'hA5A5_5A5A, 1'b0);
            push(1'b1, 5'(10 + i), 32'h1256_7834, 1'b0);
        end
        @(negedge clk_i);
        fork
            begin
                for (int i = 0; i < 3; i++) issue(0, 32'hAAAA_5555, 32'h0F0F_0F0F, 3'd2, 5'(1 + i));
                bus.req0_valid_i = 1'b0;
            end
            begin
                for (int j = 0; j < 3; j++) issue(1, 32'h1200_0034, 32'h0056_7800, 3'd1, 5'(10 + j));
                bus.req1_valid_i = 1'b0;
            end
        join
        drain();
        check("fair_count", 64'(op_count), 64'(8));

        // Backpressure: response held, no accepts, exactly one increment on release
        @(negedge clk_i);
        bus.rsp_ready_i = 1'b0;
        push(1'b0, 5'd9, 32'hEDCB_A987, 1'b0);
        push(1'b1, 5'd4, 32'h1234_0000, 1'b0);
        issue(0, 32'h1234_5678, 32'h0, 3'd3, 5'd9);
        bus.req0_valid_i = 1'b0;
        drive_req(1, 32'hFFFF_0000, 32'h1234_5678, 3'd0, 5'd4);
        @(negedge clk_i);
        #1;
        snap = {bus.rsp_id_o, bus.rsp_rd_addr_o, bus.rsp_data_o, bus.rsp_err_o};
        cb = op_count;
        check("bp_valid", 64'(bus.rsp_valid_o), 64'(1));
        check("bp_snapshot", 64'(snap), 64'({1'b0, 5'd9, 32'hEDCB_A987, 1'b0}));
        check("bp_count_before", 64'(cb), 64'(8));
        for (int i = 0; i < 10; i++) begin
            @(negedge clk_i);
            #1;
            check("bp_hold",
                  64'({bus.rsp_id_o, bus.rsp_rd_addr_o, bus.rsp_data_o, bus.rsp_err_o,
                       bus.rsp_valid_o, bus.req0_ready_o, bus.req1_ready_o, op_count}),
                  64'({snap, 1'b1, 1'b0, 1'b0, cb}));
        end
        @(negedge clk_i);
        bus.rsp_ready_i = 1'b1;
        wait_accept(1);
        bus.req1_valid_i = 1'b0;
        #1;
        check("bp_one_increment", 64'(op_count), 64'(cb + 16'd1));
        drain();
        check("bp_final_count", 64'(op_count), 64'(10));

        // Reset during EXEC drops the operation
        @(negedge clk_i);
        issue(0, 32'h1111_1111, 32'h3333_3333, 3'd0, 5'd6);
        bus.req0_valid_i = 1'b0;
        arst_ni = 1'b0;
        #1;
        check("midrst_clear", 64'({busy, bus.rsp_valid_o, op_count, alu_rs1}), 64'(0));
        repeat (2) @(negedge clk_i);
        arst_ni = 1'b1;
        repeat (4) @(negedge clk_i);
        #1;
        check("midrst_no_rsp", 64'({bus.rsp_valid_o, busy, op_count}), 64'(0));
        @(negedge clk_i);
        push(1'b1, 5'd3, 32'hFF00_00FF, 1'b0);
        issue(1, 32'hFFFF_0000, 32'h00FF_00FF, 3'd2, 5'd3);
        bus.req1_valid_i = 1'b0;
        drain();
        check("midrst_count", 64'(op_count), 64'(1));

        repeat (3) @(negedge clk_i);
        check("queue_empty", 64'(exp_q.size()), 64'(0));
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
